// File: rtl/ddr_frame_arbiter_if.sv
// Command port between the frame arbiter and the DDR3 controller user interface.
// One burst command is in flight at a time; burst_done closes its data phase.
interface ddr_frame_arbiter_if #(
  parameter int ADDR_W = 28
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic              burst_done;

  modport master (
    output cmd_valid, cmd_we, cmd_addr,
    input  cmd_ready, burst_done
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr,
    output cmd_ready, burst_done
  );
endinterface

// File: rtl/ddr_frame_arbiter.sv
// Round-robin write/read burst scheduler for the triple-buffered video frame store.
// state | meaning: IDLE wait calibration | ARB apply frame starts or grant | CMD offer command | DATA wait burst_done
module ddr_frame_arbiter #(
  parameter int                ADDR_W       = 28,
  parameter int                BURST_BYTES  = 256,
  parameter int                FRAME_BURSTS = 7200,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(28'h040_0000)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_done,
  input  logic                   wr_frame_start,
  input  logic                   wr_level_ok,
  input  logic                   rd_frame_start,
  input  logic                   rd_space_ok,
  ddr_frame_arbiter_if.master    cmd,
  output logic [1:0]             wr_buf,
  output logic [1:0]             rd_buf,
  output logic                   wr_drop,
  output logic                   rd_underrun
);
  localparam int                CNT_W   = $clog2(FRAME_BURSTS + 1);
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(FRAME_BURSTS);
  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_BYTES);

  typedef enum logic [1:0] {IDLE, ARB, CMD, DATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              wr_active, rd_active;
  logic              wr_pend, rd_pend;
  logic              last_grant_w;
  logic [1:0]        last_done, last_done_nxt;
  logic              consume, grant_w, grant_r;
  logic              wreq, rreq, wr_frame_full;
  logic [ADDR_W-1:0] addr_w, addr_r;

  assign wreq          = wr_active && wr_level_ok && (wr_cnt < FULL);
  assign rreq          = rd_active && rd_space_ok && (rd_cnt < FULL);
  assign wr_frame_full = wr_active && (wr_cnt == FULL);
  assign addr_w        = ADDR_W'(wr_buf) * FRAME_STRIDE + ADDR_W'(wr_cnt) * BURST_A;
  assign addr_r        = ADDR_W'(rd_buf) * FRAME_STRIDE + ADDR_W'(rd_cnt) * BURST_A;

  // Pending frame starts take a whole ARB cycle so a grant never sees half-updated buffers.
  always_comb begin
    state_nxt     = state;
    consume       = 1'b0;
    grant_w       = 1'b0;
    grant_r       = 1'b0;
    last_done_nxt = last_done;
    case (state)
      IDLE: if (init_done) state_nxt = ARB;
      ARB: begin
        if (wr_pend || rd_pend) begin
          consume = 1'b1;
          if (wr_pend && wr_frame_full) last_done_nxt = wr_buf;
        end else if (wreq && (!rreq || !last_grant_w)) begin
          grant_w   = 1'b1;
          state_nxt = CMD;
        end else if (rreq) begin
          grant_r   = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD:  if (cmd.cmd_valid && cmd.cmd_ready) state_nxt = DATA;
      DATA: if (cmd.burst_done) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_we   <= 1'b0;
      cmd.cmd_addr <= '0;
      wr_buf       <= 2'd1;
      rd_buf       <= 2'd0;
      last_done    <= 2'd0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      wr_active    <= 1'b0;
      rd_active    <= 1'b0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      last_grant_w <= 1'b0;
      wr_drop      <= 1'b0;
      rd_underrun  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_drop     <= 1'b0;
      rd_underrun <= 1'b0;
      wr_pend     <= wr_frame_start || (wr_pend && !consume);
      rd_pend     <= rd_frame_start || (rd_pend && !consume);

      if (consume && wr_pend) begin
        if (wr_frame_full) begin
          last_done <= wr_buf;
          wr_buf    <= 2'd3 - wr_buf - rd_buf;
        end else if (wr_active) begin
          wr_drop <= 1'b1;
        end
        wr_cnt    <= '0;
        wr_active <= 1'b1;
      end

      // Read picks up last_done_nxt so a same-cycle completed write frame is shown at once.
      if (consume && rd_pend) begin
        rd_buf      <= last_done_nxt;
        rd_underrun <= rd_active && (rd_cnt < FULL);
        rd_cnt      <= '0;
        rd_active   <= 1'b1;
      end

      if (grant_w || grant_r) begin
        cmd.cmd_valid <= 1'b1;
        cmd.cmd_we    <= grant_w;
        cmd.cmd_addr  <= grant_w ? addr_w : addr_r;
        last_grant_w  <= grant_w;
      end else if (cmd.cmd_valid && cmd.cmd_ready) begin
        cmd.cmd_valid <= 1'b0;
      end

      if (state == DATA && cmd.burst_done) begin
        if (last_grant_w) begin
          if (wr_cnt < FULL) wr_cnt <= wr_cnt + 1'b1;
        end else begin
          if (rd_cnt < FULL) rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Directed bench for ddr_frame_arbiter with a 4-burst frame and a 3-cycle controller model.
module tb_ddr_frame_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, init_done, wr_frame_start, wr_level_ok, rd_frame_start, rd_space_ok;
  logic [1:0] wr_buf, rd_buf;
  logic       wr_drop, rd_underrun;

  int n_checks = 0;
  int n_errors = 0;
  int drop_cnt = 0;
  int unr_cnt  = 0;
  int done_cnt = 0;
  logic [28:0] cmd_log [$];

  ddr_frame_arbiter_if #(.ADDR_W(28)) ifc ();

  ddr_frame_arbiter #(
    .ADDR_W(28), .BURST_BYTES(256), .FRAME_BURSTS(4), .FRAME_STRIDE(28'h040_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_frame_start(wr_frame_start), .wr_level_ok(wr_level_ok),
    .rd_frame_start(rd_frame_start), .rd_space_ok(rd_space_ok),
    .cmd(ifc.master),
    .wr_buf(wr_buf), .rd_buf(rd_buf), .wr_drop(wr_drop), .rd_underrun(rd_underrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wr();
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_frame_start = 1'b1;
    @(negedge clk);
    rd_frame_start = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (cmd_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(cmd_log.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!ifc.cmd_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(ifc.cmd_valid), 32'd1);
  endtask

  // Controller model: logs each accepted command, pulses burst_done 3 cycles later.
  initial begin
    ifc.burst_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ifc.burst_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) ifc.burst_done = 1'b1;
      end
      if (ifc.cmd_valid && ifc.cmd_ready) begin
        cmd_log.push_back({ifc.cmd_we, ifc.cmd_addr});
        done_cnt = 3;
      end
      if (wr_drop) drop_cnt++;
      if (rd_underrun) unr_cnt++;
    end
  end

  initial begin
    logic [28:0] alt [8];
    int          base;
    logic        saw, stable;
    logic [1:0]  r;

    alt = '{{1'b1, 28'h040_0000}, {1'b0, 28'h000_0000}, {1'b1, 28'h040_0100}, {1'b0, 28'h000_0100},
            {1'b1, 28'h040_0200}, {1'b0, 28'h000_0200}, {1'b1, 28'h040_0300}, {1'b0, 28'h000_0300}};

    rst_n = 1'b0; init_done = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    wr_level_ok = 1'b1; rd_space_ok = 1'b1; ifc.cmd_ready = 1'b1;
    tick(3);
    check_val("rst_valid", 32'(ifc.cmd_valid), 32'd0);
    check_val("rst_we", 32'(ifc.cmd_we), 32'd0);
    check_val("rst_addr", 32'(ifc.cmd_addr), 32'd0);
    check_val("rst_wr_buf", 32'(wr_buf), 32'd1);
    check_val("rst_rd_buf", 32'(rd_buf), 32'd0);
    check_val("rst_drop", 32'(wr_drop), 32'd0);
    check_val("rst_underrun", 32'(rd_underrun), 32'd0);
    rst_n = 1'b1;

    saw = 1'b0;
    repeat (20) begin tick(1); if (ifc.cmd_valid) saw = 1'b1; end
    check_val("idle_no_valid", 32'(saw), 32'd0);
    init_done = 1'b1;
    repeat (10) begin tick(1); if (ifc.cmd_valid) saw = 1'b1; end
    check_val("inactive_no_valid", 32'(saw), 32'd0);
    check_val("inactive_no_cmd", 32'(cmd_log.size()), 32'd0);

    // Both sides start; first write held with cmd_ready low, then alternate.
    wr_level_ok = 1'b0; rd_space_ok = 1'b0; ifc.cmd_ready = 1'b0;
    pulse_wr();
    pulse_rd();
    tick(2);
    wr_level_ok = 1'b1;
    wait_valid("hold_valid_seen", 20);
    check_val("hold_we", 32'(ifc.cmd_we), 32'd1);
    check_val("hold_addr", 32'(ifc.cmd_addr), 32'h040_0000);
    stable = 1'b1;
    repeat (5) begin
      tick(1);
      if (!ifc.cmd_valid || ifc.cmd_addr !== 28'h040_0000) stable = 1'b0;
    end
    check_val("hold_stable", 32'(stable), 32'd1);
    ifc.cmd_ready = 1'b1; rd_space_ok = 1'b1;
    wait_log("alt_done", 8, 300);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("alt_cmd%0d", i), 32'(cmd_log[i]), 32'(alt[i]));
    tick(20);
    check_val("saturated", 32'(cmd_log.size()), 32'd8);

    // Completed write frame rotates buffers; read follows last_done.
    wr_level_ok = 1'b0; rd_space_ok = 1'b0;
    pulse_wr(); tick(3);
    check_val("swap_wr_buf", 32'(wr_buf), 32'd2);
    check_val("swap_no_drop", 32'(drop_cnt), 32'd0);
    pulse_rd(); tick(3);
    check_val("swap_rd_buf", 32'(rd_buf), 32'd1);
    check_val("swap_no_underrun", 32'(unr_cnt), 32'd0);

    // Abandon a write frame after 2 bursts.
    base = cmd_log.size();
    wr_level_ok = 1'b1;
    wait_log("drop_two", base + 2, 100);
    wr_level_ok = 1'b0;
    check_val("buf2_addr0", 32'(cmd_log[base]), 32'({1'b1, 28'h080_0000}));
    check_val("buf2_addr1", 32'(cmd_log[base + 1]), 32'({1'b1, 28'h080_0100}));
    tick(6);
    pulse_wr(); tick(3);
    check_val("drop_pulse", 32'(drop_cnt), 32'd1);
    check_val("drop_wr_buf", 32'(wr_buf), 32'd2);
    base = cmd_log.size();
    wr_level_ok = 1'b1;
    wait_log("refill", base + 4, 100);
    wr_level_ok = 1'b0;
    for (int i = 0; i < 4; i++)
      check_val($sformatf("refill%0d", i), 32'(cmd_log[base + i]), 32'({1'b1, 28'h080_0000 + 28'(i * 256)}));
    tick(6);

    // Restart an output frame after 1 of 4 reads.
    base = cmd_log.size();
    rd_space_ok = 1'b1;
    wait_log("unr_one", base + 1, 100);
    rd_space_ok = 1'b0;
    check_val("unr_addr", 32'(cmd_log[base]), 32'({1'b0, 28'h040_0000}));
    tick(6);
    pulse_rd(); tick(3);
    check_val("unr_pulse", 32'(unr_cnt), 32'd1);
    check_val("unr_rd_buf", 32'(rd_buf), 32'd1);

    // Simultaneous starts while a read is parked in CMD.
    ifc.cmd_ready = 1'b0; rd_space_ok = 1'b1;
    wait_valid("cmd_park", 20);
    check_val("park_addr", 32'(ifc.cmd_addr), 32'h040_0000);
    wr_frame_start = 1'b1; rd_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    tick(2);
    check_val("inflight_addr", 32'(ifc.cmd_addr), 32'h040_0000);
    check_val("inflight_wr_buf", 32'(wr_buf), 32'd2);
    base = cmd_log.size();
    ifc.cmd_ready = 1'b1;
    wait_log("both_reads", base + 2, 100);
    rd_space_ok = 1'b0;
    check_val("both_rd0", 32'(cmd_log[base]), 32'({1'b0, 28'h040_0000}));
    check_val("both_rd1", 32'(cmd_log[base + 1]), 32'({1'b0, 28'h080_0000}));
    check_val("both_wr_buf", 32'(wr_buf), 32'd0);
    check_val("both_rd_buf", 32'(rd_buf), 32'd2);
    check_val("both_underrun", 32'(unr_cnt), 32'd2);
    check_val("both_no_drop", 32'(drop_cnt), 32'd1);

    for (int i = 0; i < 50; i++) begin
      r = 2'($urandom_range(1, 3));
      wr_level_ok = 1'($urandom_range(0, 1));
      rd_space_ok = 1'($urandom_range(0, 1));
      wr_frame_start = r[0]; rd_frame_start = r[1];
      @(negedge clk);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      tick($urandom_range(1, 12));
      check_val($sformatf("inv_%0d", i), 32'(wr_buf != rd_buf), 32'd1);
    end
    wr_level_ok = 1'b0; rd_space_ok = 1'b0;
    tick(20);

    // Asynchronous reset in the middle of a data phase.
    wr_level_ok = 1'b1;
    pulse_wr();
    base = cmd_log.size();
    wait_log("pre_reset_cmd", base + 1, 100);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(ifc.cmd_valid), 32'd0);
    check_val("arst_wr_buf", 32'(wr_buf), 32'd1);
    check_val("arst_rd_buf", 32'(rd_buf), 32'd0);
    check_val("arst_addr", 32'(ifc.cmd_addr), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ddr_frame_arbiter.md
Name: ddr_frame_arbiter

Overview:
- Schedules DDR3 burst commands for the video frame buffer.
- Shares the single memory-controller command port between two requesters:
  - the write side, which carries processed camera pixels;
  - the read side, which prefetches pixels for HDMI output.
- Manages triple buffering so the display never reads a frame that is still being written.
- Sits between the write/read pixel FIFOs and the DDR3 controller user interface, in the memory user clock domain.

Parameters:
- ADDR_W, 28, width of the controller command address (byte address).
- BURST_BYTES, 256, bytes moved per command (address increment per burst).
- FRAME_BURSTS, 7200, bursts per frame (1280x720x2 bytes / 256).
- FRAME_STRIDE, 28'h040_0000, byte distance between buffer bases; buffer n base = n*FRAME_STRIDE.

Ports:
- clk  in  1  memory user clock.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  DDR calibration complete; level.
- wr_frame_start  in  1  one-cycle pulse at the start of an input frame (already synchronised).
- wr_level_ok  in  1  write FIFO holds at least one burst.
- rd_frame_start  in  1  one-cycle pulse at the start of an output frame (already synchronised).
- rd_space_ok  in  1  read FIFO has room for one burst.
- cmd_valid  out  1  command request.
- cmd_ready  in  1  controller accepts the command when cmd_valid&&cmd_ready.
- cmd_we  out  1  1=write burst, 0=read burst.
- cmd_addr  out  ADDR_W  burst byte address.
- burst_done  in  1  one-cycle pulse when the data phase of the accepted burst completes.
- wr_buf  out  2  buffer index currently being written.
- rd_buf  out  2  buffer index currently being read.
- wr_drop  out  1  pulse: an incomplete input frame was abandoned.
- rd_underrun  out  1  pulse: an output frame restarted before all its bursts were read.

Behaviour:
- Reset values:
  - cmd_valid=0, cmd_we=0, cmd_addr=0, wr_drop=0, rd_underrun=0.
  - wr_buf=1, rd_buf=0, last_done=0.
  - wr_cnt=0, wr_active=0, rd_cnt=0, rd_active=0, last_grant=read, state=IDLE, pending flags=0.
- Invariants: wr_buf!=rd_buf and last_done!=wr_buf at all times.
- Frame-start pulses are latched into wr_pend/rd_pend in every state. They are consumed only in ARB, one cycle before arbitration.
- Write frame start (consumed):
  - If wr_active && wr_cnt==FRAME_BURSTS: last_done<=wr_buf; wr_buf<=3-wr_buf-rd_buf.
  - If wr_active && wr_cnt<FRAME_BURSTS: wr_buf unchanged; wr_drop pulses for 1 cycle.
  - In all cases: wr_cnt<=0, wr_active<=1.
- Read frame start (consumed):
  - rd_buf<=last_done, evaluated after any same-cycle write update.
  - rd_underrun pulses if rd_active && rd_cnt<FRAME_BURSTS.
  - rd_cnt<=0, rd_active<=1.
- Both pending in the same ARB cycle: apply the write update first, then the read update uses the new last_done.
- FSM:
  - IDLE: stay while !init_done; go to ARB when init_done=1.
  - ARB: compute requests and pick a grant.
    - wreq = wr_active && wr_level_ok && wr_cnt<FRAME_BURSTS.
    - rreq = rd_active && rd_space_ok && rd_cnt<FRAME_BURSTS.
    - A single request is granted. Both requesting: grant the opposite of last_grant (round robin). Neither: stay in ARB.
    - On grant, register cmd_we, cmd_addr = buf*FRAME_STRIDE + cnt*BURST_BYTES (truncated to ADDR_W), and last_grant; assert cmd_valid; go to CMD.
  - CMD: hold cmd_valid/cmd_we/cmd_addr stable until cmd_ready. On handshake, cmd_valid<=0 the next cycle; go to DATA.
  - DATA: wait for burst_done. Then increment the granted side's counter; go to ARB.
- Latency: at least 1 cycle from ARB entry to cmd_valid. A command can be accepted the first cycle cmd_valid is high.
- At most one command is outstanding. Frame-start updates never alter an in-flight command's address.
- burst_done outside DATA is ignored.
- init_done falling is ignored after IDLE.
- Counter saturates at FRAME_BURSTS; no further requests from that side until its next frame start.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). An outstanding command is abandoned.

Test Plan:
- Reset, init_done=0 for 20 cycles, both sides requesting -> cmd_valid stays 0. After init_done=1, no cmd_valid until a frame start activates a side.
- Write start only, wr_level_ok=1, cmd_ready=1, burst_done 3 cycles after each accept -> cmd_we=1, addresses 0x0400000, 0x0400100, 0x0400200...; cmd_valid holds while cmd_ready=0 for 5 cycles with a stable address.
- Both sides active and always requesting -> grants alternate W,R,W,R. Read addresses 0x0000000, 0x0000100...
- Complete a write frame (FRAME_BURSTS=4 in bench), then wr_frame_start -> wr_buf=2, last_done=1. Next rd_frame_start -> rd_buf=1. wr_buf never equals rd_buf over 50 random frame starts.
- wr_frame_start after 2 of 4 bursts -> wr_drop pulses, wr_buf unchanged, wr_cnt=0. rd_frame_start after 1 of 4 -> rd_underrun pulses.
- wr_frame_start and rd_frame_start pulses during CMD, and simultaneously -> applied in next ARB with write first. rst_n low during DATA -> cmd_valid=0, wr_buf=1, rd_buf=0 without a clock edge.
